// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    BRANCH,
    PENDING,
    JUMP
  } redirect_src_t;

  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-controller bus: redirect sources, PC feedback and imem handshake.
interface fetch_controller_if #(
  parameter int PC_WIDTH = 32
);
  logic                hazard;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc_current;
  logic                imem_ready;
  logic                imem_req;
  logic [PC_WIDTH-1:0] pc_next;
  logic                pc_hold;
  logic                flush_if_id;
  logic                fetch_valid;
  logic                imem_timeout;

  modport master (
    input  hazard, branch_taken, branch_target,
    input  jump, jump_target, pc_current, imem_ready,
    output imem_req, pc_next, pc_hold,
    output flush_if_id, fetch_valid, imem_timeout
  );

  modport slave (
    output hazard, branch_taken, branch_target,
    output jump, jump_target, pc_current, imem_ready,
    input  imem_req, pc_next, pc_hold,
    input  flush_if_id, fetch_valid, imem_timeout
  );
endinterface

// File: rtl/fetch_redirect_latch.sv
// Holds a redirect that arrived while an imem request was outstanding.
module fetch_redirect_latch #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                branch_set_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_set_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic                pending_valid_o,
  output logic [PC_WIDTH-1:0] pending_target_o
);

  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] target_q, target_d;

  // A branch is older than any jump, so it always wins the slot.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (branch_set_i) begin
      valid_d  = 1'b1;
      target_d = branch_target_i;
    end else if (jump_set_i && !valid_q) begin
      valid_d  = 1'b1;
      target_d = jump_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign pending_valid_o  = valid_q;
  assign pending_target_o = target_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: PC next/hold, imem handshake, redirect arbitration.
// Optional stall counter port enabled by FETCH_CTRL_STALL_CNT_EN.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int PC_STEP     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.master bus
`ifdef FETCH_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PC_WIDTH-1:0] ALIGN =
    PC_ALIGN_MASK[PC_WIDTH-1:0];
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  fetch_state_t        state_q, state_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_target;
  logic                pend_set, pend_clr;
  redirect_src_t       src;
  logic [PC_WIDTH-1:0] target;
  logic                redir, seq;
  logic                req, hold, flush, fvalid;
  logic [PC_WIDTH-1:0] nxt;

  always_comb begin
    src = NONE;
    if (bus.branch_taken)      src = BRANCH;
    else if (pend_valid)       src = PENDING;
    else if (bus.jump)         src = JUMP;
  end

  always_comb begin
    target = '0;
    unique case (src)
      BRANCH:  target = bus.branch_target;
      PENDING: target = pend_target;
      JUMP:    target = bus.jump_target;
      default: target = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    req        = 1'b0;
    redir      = 1'b0;
    seq        = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (src != NONE) begin
          req = !bus.hazard;
          if (bus.hazard || bus.imem_ready) begin
            redir    = 1'b1;
            pend_clr = 1'b1;
          end else begin
            pend_set   = 1'b1;
            state_d    = WAIT;
            wait_cnt_d = CW'(1);
          end
        end else if (!bus.hazard) begin
          req = 1'b1;
          if (bus.imem_ready) begin
            seq = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = CW'(1);
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (bus.imem_ready) begin
          state_d    = FETCH;
          wait_cnt_d = '0;
          pend_clr   = 1'b1;
          redir      = (src != NONE);
          seq        = (src == NONE);
        end else begin
          pend_set = 1'b1;
          if (wait_cnt_q != TMO) wait_cnt_d = wait_cnt_q + CW'(1);
          if (wait_cnt_d == TMO) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
      req        = 1'b0;
      redir      = 1'b0;
      seq        = 1'b0;
      pend_set   = 1'b0;
    end
  end

  always_comb begin
    hold   = 1'b1;
    flush  = 1'b0;
    fvalid = 1'b0;
    nxt    = reset ? bus.pc_current : '0;
    if (redir) begin
      hold  = 1'b0;
      flush = 1'b1;
      nxt   = target & ALIGN;
    end else if (seq) begin
      hold   = 1'b0;
      fvalid = 1'b1;
      nxt    = bus.pc_current + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  fetch_redirect_latch #(
    .PC_WIDTH(PC_WIDTH)
  ) u_latch (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (pend_clr),
    .branch_set_i    (pend_set && bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .jump_set_i      (pend_set && bus.jump),
    .jump_target_i   (bus.jump_target),
    .pending_valid_o (pend_valid),
    .pending_target_o(pend_target)
  );

`ifdef FETCH_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset)    stall_q <= '0;
    else if (hold) stall_q <= stall_q + 32'd1;
  end

  assign stall_count = stall_q;
`endif

  assign bus.imem_req     = req;
  assign bus.pc_next      = nxt;
  assign bus.pc_hold      = hold;
  assign bus.flush_if_id  = flush;
  assign bus.fetch_valid  = fvalid;
  assign bus.imem_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed table, timeout/reset sequence and randomized model check.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_controller_if #(.PC_WIDTH(32)) bus ();

  fetch_controller #(
    .PC_WIDTH(32),
    .PC_STEP(4),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        rst, hz, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt, pc;
    logic        rdy;
    logic        req, hold;
    logic [31:0] nxt;
    logic        cn, flush, valid, tmo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    string n, logic r, logic hz, logic br, logic [31:0] bt,
    logic j, logic [31:0] jt, logic [31:0] pc, logic rdy,
    logic req, logic hold, logic [31:0] nxt, logic cn,
    logic flush, logic valid, logic tmo);
    vec_t v;
    v.name = n; v.rst = r; v.hz = hz; v.br = br; v.bt = bt;
    v.j = j; v.jt = jt; v.pc = pc; v.rdy = rdy;
    v.req = req; v.hold = hold; v.nxt = nxt; v.cn = cn;
    v.flush = flush; v.valid = valid; v.tmo = tmo;
    return v;
  endfunction

  task automatic drive(logic r, logic hz, logic br, logic [31:0] bt,
                       logic j, logic [31:0] jt, logic [31:0] pc,
                       logic rdy);
    rst               = r;
    bus.hazard        = hz;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.pc_current    = pc;
    bus.imem_ready    = rdy;
  endtask

  task automatic check(string n, logic req, logic hold,
                       logic [31:0] nxt, logic cn, logic flush,
                       logic valid, logic tmo);
    logic [4:0] act, exp;
    act = {bus.imem_req, bus.pc_hold, bus.flush_if_id,
           bus.fetch_valid, bus.imem_timeout};
    exp = {req, hold, flush, valid, tmo};
    checks++;
    if (act !== exp || (cn && bus.pc_next !== nxt)) begin
      errors++;
      $display("FAIL %s: got req/hold/flush/valid/tmo=%b next=%h, want %b next=%h%s",
               n, act, bus.pc_next, exp, nxt, cn ? "" : " (next unchecked)");
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state (what the fetch stage is doing, per the rules)
  int          m_phase;
  logic [31:0] m_pend[$];
  int          m_waited;
  logic        m_tmo;
  logic [31:0] m_pc;

  task automatic model_step(output logic req, output logic hold,
                            output logic [31:0] nxt, output logic cn,
                            output logic flush, output logic valid,
                            output logic tmo);
    logic        has;
    logic [31:0] tg;
    req = 0; hold = 1; nxt = 0; cn = 0; flush = 0; valid = 0;
    tmo = m_tmo;
    has = 0; tg = 0;
    if (bus.branch_taken) begin has = 1; tg = bus.branch_target; end
    else if (m_pend.size() > 0) begin has = 1; tg = m_pend[0]; end
    else if (bus.jump) begin has = 1; tg = bus.jump_target; end
    if (!rst) begin
      cn = 1;
      m_phase = 0; m_pend.delete(); m_waited = 0; m_tmo = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (has && (bus.hazard || bus.imem_ready)) begin
        req = !bus.hazard; hold = 0; flush = 1; cn = 1;
        nxt = {tg[31:2], 2'b00};
        m_pend.delete();
      end else if (has) begin
        req = 1; m_pend.delete(); m_pend.push_back(tg);
        m_phase = 2; m_waited = 1;
      end else if (!bus.hazard) begin
        req = 1;
        if (bus.imem_ready) begin
          hold = 0; valid = 1; cn = 1; nxt = bus.pc_current + 4;
        end else begin
          m_phase = 2; m_waited = 1;
        end
      end
    end else begin
      req = 1;
      if (bus.imem_ready) begin
        hold = 0; cn = 1;
        if (has) begin flush = 1; nxt = {tg[31:2], 2'b00}; end
        else begin valid = 1; nxt = bus.pc_current + 4; end
        m_pend.delete(); m_phase = 1; m_waited = 0;
      end else begin
        if (bus.branch_taken) begin
          m_pend.delete(); m_pend.push_back(bus.branch_target);
        end else if (bus.jump && m_pend.size() == 0) begin
          m_pend.push_back(bus.jump_target);
        end
        if (m_waited < 64) m_waited++;
        if (m_waited >= 64) m_tmo = 1;
      end
    end
  endtask

  initial begin
    logic        req, hold, cn, flush, valid, tmo;
    logic [31:0] nxt;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    tbl.push_back(mk("rst0",  0,0,0,0,0,0,0,1, 0,1,0,1,0,0,0));
    tbl.push_back(mk("rst1",  0,0,0,0,0,0,0,1, 0,1,0,1,0,0,0));
    tbl.push_back(mk("rst2",  0,0,0,0,0,0,0,1, 0,1,0,1,0,0,0));
    tbl.push_back(mk("idle",  1,0,0,0,0,0,0,1, 0,1,0,0,0,0,0));
    tbl.push_back(mk("seq0",  1,0,0,0,0,0,0,1, 1,0,4,1,0,1,0));
    tbl.push_back(mk("wt1",   1,0,0,0,0,0,'h100,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("wt2",   1,0,0,0,0,0,'h100,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("wt3",   1,0,0,0,0,0,'h100,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("wtok",  1,0,0,0,0,0,'h100,1, 1,0,'h104,1,0,1,0));
    tbl.push_back(mk("w3a",   1,0,0,0,0,0,'h104,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("w3jmp", 1,0,0,0,1,'h200,'h104,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("w3br",  1,0,1,'h300,0,0,'h104,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("w3ok",  1,0,0,0,0,0,'h104,1, 1,0,'h300,1,1,0,0));
    tbl.push_back(mk("hzbr",  1,1,1,'h40,0,0,'h300,0, 0,0,'h40,1,1,0,0));
    tbl.push_back(mk("hz",    1,1,0,0,0,0,'h40,1, 0,1,0,0,0,0,0));
    tbl.push_back(mk("wrap",  1,0,0,0,0,0,'hFFFFFFFC,1, 1,0,0,1,0,1,0));
    tbl.push_back(mk("align", 1,0,0,0,1,'h123,0,1, 1,0,'h120,1,1,0,0));
    tbl.push_back(mk("jpend", 1,0,0,0,1,'h500,'h120,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("jpok",  1,0,0,0,0,0,'h120,1, 1,0,'h500,1,1,0,0));
    tbl.push_back(mk("brjmp", 1,0,1,'h600,1,'h700,'h500,1, 1,0,'h600,1,1,0,0));
    tbl.push_back(mk("j1",    1,0,0,0,1,'h800,'h600,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("j2",    1,0,0,0,1,'h900,'h600,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("j1win", 1,0,0,0,0,0,'h600,1, 1,0,'h800,1,1,0,0));
    tbl.push_back(mk("hzw0",  1,0,0,0,0,0,'h800,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk("hzw1",  1,1,0,0,0,0,'h800,1, 1,0,'h804,1,0,1,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].hz, tbl[i].br, tbl[i].bt,
            tbl[i].j, tbl[i].jt, tbl[i].pc, tbl[i].rdy);
      @(negedge clk);
      check(tbl[i].name, tbl[i].req, tbl[i].hold, tbl[i].nxt,
            tbl[i].cn, tbl[i].flush, tbl[i].valid, tbl[i].tmo);
      tick();
    end

    // Timeout: 64 unanswered cycles, sticky afterwards, cleared by reset
    for (int k = 1; k <= 64; k++) begin
      drive(1, 0, 0, 0, 0, 0, 'h1000, 0);
      @(negedge clk);
      check($sformatf("tmo_wait%0d", k), 1, 1, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 'h1000, 1);
    @(negedge clk);
    check("tmo_set", 1, 0, 'h1004, 1, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 'h1004, 1);
    @(negedge clk);
    check("tmo_sticky", 1, 0, 'h1008, 1, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0, 1, 'hA00, 'h1008, 0);
    @(negedge clk);
    check("pend_mid", 1, 1, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 'h1008, 1);
    @(negedge clk);
    check("rst_wait", 0, 1, 0, 1, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 'h1008, 1);
    @(negedge clk);
    check("rst_idle", 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 'h1008, 1);
    @(negedge clk);
    check("pend_lost", 1, 0, 'h100C, 1, 0, 1, 0);
    tick();

    // Randomized run against the reference model
    m_phase = 0; m_waited = 0; m_tmo = 0; m_pc = 0;
    m_pend.delete();
    for (int c = 0; c < 4000; c++) begin
      drive((c < 2) ? 1'b0 : ($urandom_range(99) >= 2),
            $urandom_range(99) < 25,
            $urandom_range(99) < 15, $urandom,
            $urandom_range(99) < 15, $urandom,
            m_pc,
            $urandom_range(99) < ((c % 500 > 400) ? 2 : 60));
      @(negedge clk);
      model_step(req, hold, nxt, cn, flush, valid, tmo);
      check($sformatf("rand%0d", c), req, hold, nxt, cn,
            flush, valid, tmo);
      if (!hold) m_pc = nxt;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
